uart_baud_tick_gen: RTL

//  Programmable fractional-N baud tick generator for the UART path; successor to the fixed-rate rx clock divider.
//  - Emits a one-cycle rx_tick at BAUD*OVERSAMPLE and a one-cycle tx_tick at BAUD.
//  - Divisor is run-time loadable, fixed point (integer.fraction), and takes effect glitch-free at a tick boundary.
//  - Sits between the board clock and the UART rx sampler / tx shifter; all consumers use clk with tick enables.

---
 rtl/uart_baud_tick_gen_if.sv | 30 +++
 rtl/uart_baud_tick_gen.sv | 117 +++++++++++
 2 files changed

// File: rtl/uart_baud_tick_gen_if.sv
// Control and tick bus of the fractional-N baud tick generator.
// The master drives the enable and divisor-load strobe; the slave (the
// generator) returns the divisor in effect, the pending flag and the ticks.
interface uart_baud_tick_gen_if #(
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4,
    parameter int OVERSAMPLE = 16
);
    localparam int DIV_WIDTH   = INT_WIDTH + FRAC_WIDTH;
    localparam int PHASE_WIDTH = $clog2(OVERSAMPLE);

    logic                   en;
    logic                   div_load;
    logic [DIV_WIDTH-1:0]   div_in;
    logic [DIV_WIDTH-1:0]   div_cur;
    logic                   div_pending;
    logic                   rx_tick;
    logic                   tx_tick;
    logic [PHASE_WIDTH-1:0] os_phase;

    modport master (
        output en, div_load, div_in,
        input  div_cur, div_pending, rx_tick, tx_tick, os_phase
    );

    modport slave (
        input  en, div_load, div_in,
        output div_cur, div_pending, rx_tick, tx_tick, os_phase
    );
endinterface

// File: rtl/uart_baud_tick_gen.sv
// Programmable fractional-N baud tick generator.
// rx_tick pulses once per oversample period (average length div_cur/2^FRAC_WIDTH
// clocks, realised as div_int or div_int+1 cycle periods from a fraction
// accumulator); tx_tick marks every OVERSAMPLE-th rx_tick. A new divisor is
// swapped in only at a period boundary so no period is ever truncated.
module uart_baud_tick_gen #(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4,
    parameter logic [INT_WIDTH+FRAC_WIDTH-1:0] DEFAULT_DIV =
        (INT_WIDTH+FRAC_WIDTH)'((64'(CLOCK_RATE) * 64'(2 ** (FRAC_WIDTH + 1))
                                + 64'(BAUD_RATE) * 64'(OVERSAMPLE))
                               / (64'(2) * 64'(BAUD_RATE) * 64'(OVERSAMPLE)))
) (
    input logic                  clk,
    input logic                  rst,
    uart_baud_tick_gen_if.slave  bus
);
    localparam int DIV_WIDTH   = INT_WIDTH + FRAC_WIDTH;
    localparam int PHASE_WIDTH = $clog2(OVERSAMPLE);
    // One extra bit so a carry-extended period of max integer divisor fits.
    localparam int CNT_WIDTH   = INT_WIDTH + 1;

    logic [CNT_WIDTH-1:0]   cnt;
    logic [FRAC_WIDTH-1:0]  frac_acc;
    logic                   carry;       // current period is one cycle longer
    logic [DIV_WIDTH-1:0]   div_cur;
    logic [DIV_WIDTH-1:0]   pend_div;
    logic                   pend_valid;
    logic                   rx_tick;
    logic                   tx_tick;
    logic [PHASE_WIDTH-1:0] os_phase;

    logic [DIV_WIDTH-1:0]   div_clamped;
    logic [DIV_WIDTH-1:0]   div_next;
    logic [CNT_WIDTH-1:0]   period_last;
    logic [FRAC_WIDTH:0]    sum;
    logic                   wrap;
    logic                   bit_end;

    // Clamp the requested integer part to at least 2 so ticks never touch.
    always_comb begin
        div_clamped = bus.div_in;
        if (bus.div_in[DIV_WIDTH-1:FRAC_WIDTH] < INT_WIDTH'(2))
            div_clamped[DIV_WIDTH-1:FRAC_WIDTH] = INT_WIDTH'(2);
    end

    // Period bookkeeping: wrap point, divisor for the next period, accumulator step.
    always_comb begin
        period_last = {1'b0, div_cur[DIV_WIDTH-1:FRAC_WIDTH]} + CNT_WIDTH'(carry)
                      - CNT_WIDTH'(1);
        wrap        = bus.en && (cnt == period_last);
        bit_end     = (os_phase == PHASE_WIDTH'(OVERSAMPLE - 1));
        // A load coinciding with the wrap beats an older pending value.
        if (bus.div_load)
            div_next = div_clamped;
        else if (pend_valid)
            div_next = pend_div;
        else
            div_next = div_cur;
        sum = {1'b0, frac_acc} + {1'b0, div_next[FRAC_WIDTH-1:0]};
    end

    // Counter, accumulator, divisor swap and registered tick outputs.
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            cnt        <= '0;
            frac_acc   <= '0;
            carry      <= 1'b0;
            div_cur    <= DEFAULT_DIV;
            pend_div   <= '0;
            pend_valid <= 1'b0;
            rx_tick    <= 1'b0;
            tx_tick    <= 1'b0;
            os_phase   <= '0;
        end else if (!bus.en) begin
            rx_tick <= 1'b0;
            tx_tick <= 1'b0;
            // While stopped a load applies at once and restarts the bit timing.
            if (bus.div_load) begin
                div_cur    <= div_clamped;
                cnt        <= '0;
                frac_acc   <= '0;
                carry      <= 1'b0;
                os_phase   <= '0;
                pend_valid <= 1'b0;
            end
        end else if (wrap) begin
            cnt        <= '0;
            div_cur    <= div_next;
            pend_valid <= 1'b0;
            frac_acc   <= sum[FRAC_WIDTH-1:0];
            carry      <= sum[FRAC_WIDTH];
            rx_tick    <= 1'b1;
            tx_tick    <= bit_end;
            os_phase   <= bit_end ? '0 : os_phase + PHASE_WIDTH'(1);
        end else begin
            cnt     <= cnt + CNT_WIDTH'(1);
            rx_tick <= 1'b0;
            tx_tick <= 1'b0;
            if (bus.div_load) begin
                pend_div   <= div_clamped;
                pend_valid <= 1'b1;
            end
        end
    end

    assign bus.div_cur     = div_cur;
    assign bus.div_pending = pend_valid;
    assign bus.rx_tick     = rx_tick;
    assign bus.tx_tick     = tx_tick;
    assign bus.os_phase    = os_phase;
endmodule
